// File: rtl/video_stream_expander.sv
// Pixel-stream expander: 2-entry skid FIFO, per-channel bit-replication widening, frame SOP/EOP tracking with resync.
// Optional test-pattern generator enabled by defining VIDEO_EXPANDER_PATTERN_EN (adds pattern_sel input).
module video_stream_expander #(
    parameter int IN_BITS  = 4,
    parameter int OUT_BITS = 8,
    parameter int PAD_BITS = 2,
    parameter int WIDTH    = 320,
    parameter int HEIGHT   = 240
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [3*IN_BITS-1:0]                in_data,
    input  logic                                in_sof,
    input  logic                                in_valid,
    output logic                                in_ready,
    output logic [3*(OUT_BITS+PAD_BITS)-1:0]    data,
    output logic                                startofpacket,
    output logic                                endofpacket,
    output logic                                valid,
    input  logic                                ready,
    output logic                                frame_done,
`ifdef VIDEO_EXPANDER_PATTERN_EN
    input  logic [1:0]                          pattern_sel,
`endif
    output logic                                sync_error
);
    localparam int CH_OUT = OUT_BITS + PAD_BITS;
    localparam int DW     = 3 * CH_OUT;
    localparam int XW     = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    logic [3*IN_BITS:0]   mem_q [2];
    logic                 wr_ptr_q, rd_ptr_q;
    logic [1:0]           count_q, count_d;
    logic [XW-1:0]        x_q, x_d, x_base;
    logic [YW-1:0]        y_q, y_d, y_base;
    logic                 frame_done_q, sync_error_q;

    logic                 push, pop;
    logic [3*IN_BITS:0]   head;
    logic                 head_sof;
    logic [3*IN_BITS-1:0] head_px;
    logic                 at_origin, at_last, sop_raw, eop_raw;
    logic [OUT_BITS-1:0]  pix_exp  [3];
    logic [OUT_BITS-1:0]  chan_val [3];
    logic [DW-1:0]        data_pre;

    assign valid     = (count_q != 2'd0);
    assign in_ready  = reset_n & (count_q != 2'd2);
    assign push      = in_valid & in_ready;
    assign pop       = valid & ready;
    assign head      = mem_q[rd_ptr_q];
    assign head_sof  = head[3*IN_BITS];
    assign head_px   = head[3*IN_BITS-1:0];
    assign at_origin = (x_q == '0) && (y_q == '0);
    assign at_last   = (x_q == XW'(WIDTH-1)) && (y_q == YW'(HEIGHT-1));
    assign sop_raw   = head_sof | at_origin;
    assign eop_raw   = ~head_sof & at_last;

    // Output bit gi (from MSB) copies input bit gi mod IN_BITS (from MSB): MSB-first replication.
    for (genvar gc = 0; gc < 3; gc++) begin : g_chan
        for (genvar gi = 0; gi < OUT_BITS; gi++) begin : g_bit
            assign pix_exp[gc][OUT_BITS-1-gi] = head_px[gc*IN_BITS + IN_BITS-1 - (gi % IN_BITS)];
        end
        assign data_pre[gc*CH_OUT + PAD_BITS +: OUT_BITS] = chan_val[gc];
        if (PAD_BITS > 0) begin : g_pad
            assign data_pre[gc*CH_OUT +: PAD_BITS] = '0;
        end
    end

`ifdef VIDEO_EXPANDER_PATTERN_EN
    logic [1:0] pattern_q;
    logic [1:0] mode;
    logic [2:0] bar;
    logic       chk;

    // The SOP pixel itself already uses the newly selected mode.
    assign mode = sop_raw ? pattern_sel : pattern_q;
    assign bar  = 3'((int'(x_q) * 8) / WIDTH);
    assign chk  = 1'((int'(x_q) ^ int'(y_q)) >> 4);

    always_comb begin
        for (int c = 0; c < 3; c++) begin
            chan_val[c] = pix_exp[c];
            if (mode == 2'd1)      chan_val[c] = {OUT_BITS{bar[c]}};
            else if (mode == 2'd2) chan_val[c] = {OUT_BITS{chk}};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)           pattern_q <= 2'd0;
        else if (pop & sop_raw) pattern_q <= pattern_sel;
    end
`else
    always_comb begin
        for (int c = 0; c < 3; c++) chan_val[c] = pix_exp[c];
    end
`endif

    assign data          = valid ? data_pre : '0;
    assign startofpacket = valid & sop_raw;
    assign endofpacket   = valid & eop_raw;
    assign frame_done    = frame_done_q;
    assign sync_error    = sync_error_q;

    // A sof-marked head restarts counting as if it were frame pixel 0.
    always_comb begin
        count_d = count_q + {1'b0, push} - {1'b0, pop};
        x_base  = head_sof ? '0 : x_q;
        y_base  = head_sof ? '0 : y_q;
        x_d     = x_q;
        y_d     = y_q;
        if (pop) begin
            if (x_base == XW'(WIDTH-1)) begin
                x_d = '0;
                y_d = (y_base == YW'(HEIGHT-1)) ? '0 : y_base + YW'(1);
            end else begin
                x_d = x_base + XW'(1);
                y_d = y_base;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            x_q          <= '0;
            y_q          <= '0;
            frame_done_q <= 1'b0;
            sync_error_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {in_sof, in_data};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            count_q      <= count_d;
            x_q          <= x_d;
            y_q          <= y_d;
            frame_done_q <= pop & eop_raw;
            sync_error_q <= pop & head_sof & ~at_origin;
        end
    end
endmodule

// File: tb/tb_video_stream_expander.sv
// Bench for video_stream_expander: queue/linear-position model checked every cycle, plus directed literal checks.
module tb_video_stream_expander;
    localparam int W = 4, H = 2, OB = 8, PB = 2, CW = OB + PB, DW = 3 * CW;

    logic clk = 1'b0, reset_n = 1'b0;
    logic [11:0] in_data = '0;
    logic in_sof = 1'b0, in_valid = 1'b0, ready = 1'b0;
    logic in_ready, startofpacket, endofpacket, valid, frame_done, sync_error;
    logic [DW-1:0] data;

    logic [14:0] in_data5 = '0;
    logic in_valid5 = 1'b0, ready5 = 1'b0;
    logic in_ready5, sop5, eop5, valid5, fd5, se5;
    logic [DW-1:0] data5;

`ifdef VIDEO_EXPANDER_PATTERN_EN
    logic [1:0] pattern_sel = 2'd0;
`endif

    always #5 clk = ~clk;

    video_stream_expander #(.IN_BITS(4), .OUT_BITS(OB), .PAD_BITS(PB), .WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_sof(in_sof), .in_valid(in_valid),
        .in_ready(in_ready), .data(data), .startofpacket(startofpacket), .endofpacket(endofpacket),
        .valid(valid), .ready(ready), .frame_done(frame_done),
`ifdef VIDEO_EXPANDER_PATTERN_EN
        .pattern_sel(pattern_sel),
`endif
        .sync_error(sync_error));

    video_stream_expander #(.IN_BITS(5), .OUT_BITS(OB), .PAD_BITS(PB), .WIDTH(W), .HEIGHT(H)) dut5 (
        .clk(clk), .reset_n(reset_n), .in_data(in_data5), .in_sof(1'b0), .in_valid(in_valid5),
        .in_ready(in_ready5), .data(data5), .startofpacket(sop5), .endofpacket(eop5),
        .valid(valid5), .ready(ready5), .frame_done(fd5),
`ifdef VIDEO_EXPANDER_PATTERN_EN
        .pattern_sel(2'd0),
`endif
        .sync_error(se5));

    int n_checks = 0, n_pass = 0;
    logic [12:0] mq[$];
    int pos = 0;
    logic exp_fd = 1'b0, exp_se = 1'b0;
    int push_cnt = 0, pop_seen = 0, sop_seen = 0, eop_seen = 0, fd_seen = 0, se_seen = 0, eop_idx = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, expv);
    endtask

    // Replicate v enough times to cover OB bits, keep the top OB bits.
    function automatic logic [OB-1:0] expand(input int v, input int ib);
        longint r = 0;
        int reps = (OB + ib - 1) / ib;
        for (int k = 0; k < reps; k++) r = (r << ib) | longint'(v);
        return OB'(r >> (reps * ib - OB));
    endfunction

    function automatic logic [DW-1:0] exp_word(input logic [11:0] px);
        return {expand(int'(px[11:8]), 4), 2'b00, expand(int'(px[7:4]), 4), 2'b00,
                expand(int'(px[3:0]), 4), 2'b00};
    endfunction

    always @(negedge clk) begin
        logic mv, esop, eeop, will_push;
        logic [12:0] h;
        if (!reset_n) begin
            mq.delete();
            pos = 0; exp_fd = 1'b0; exp_se = 1'b0;
            check("rst_valid", 64'(valid), 64'd0);
            check("rst_in_ready", 64'(in_ready), 64'd0);
            check("rst_data", 64'(data), 64'd0);
            check("rst_sop_eop", {62'd0, startofpacket, endofpacket}, 64'd0);
            check("rst_pulses", {62'd0, frame_done, sync_error}, 64'd0);
        end else begin
            mv = (mq.size() != 0);
            check("valid", 64'(valid), 64'(mv));
            check("in_ready", 64'(in_ready), 64'(mq.size() < 2));
            check("frame_done", 64'(frame_done), 64'(exp_fd));
            check("sync_error", 64'(sync_error), 64'(exp_se));
            esop = 1'b0; eeop = 1'b0; h = '0;
            if (mv) begin
                h = mq[0];
                esop = h[12] || (pos == 0);
                eeop = !h[12] && (pos == W * H - 1);
                check("data", 64'(data), 64'(exp_word(h[11:0])));
            end else begin
                check("data_idle", 64'(data), 64'd0);
            end
            check("sop", 64'(startofpacket), 64'(esop));
            check("eop", 64'(endofpacket), 64'(eeop));
            if (valid && ready) begin
                pop_seen++;
                if (startofpacket) sop_seen++;
                if (endofpacket) begin eop_seen++; eop_idx = pop_seen; end
            end
            if (frame_done) fd_seen++;
            if (sync_error) se_seen++;
            will_push = in_valid && (mq.size() < 2);
            exp_fd = 1'b0; exp_se = 1'b0;
            if (mv && ready) begin
                exp_fd = eeop;
                exp_se = h[12] && (pos != 0);
                pos = h[12] ? (1 % (W * H)) : ((pos + 1) % (W * H));
                void'(mq.pop_front());
            end
            if (will_push) begin
                mq.push_back({in_sof, in_data});
                push_cnt++;
            end
        end
    end

    task automatic send(input logic [11:0] d, input logic s);
        logic acc;
        int n = 0;
        in_data = d; in_sof = s; in_valid = 1'b1;
        do begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1; n++;
        end while (!acc && n < 50);
        if (!acc) begin n_checks++; $display("FAIL send_timeout: got no accept, expected accept within 50"); end
        in_valid = 1'b0; in_sof = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (mq.size() != 0 && n < 100) begin @(posedge clk); n++; end
        if (mq.size() != 0) begin n_checks++; $display("FAIL drain_timeout: got %0d left, expected 0", mq.size()); end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int s_sop, s_eop, s_fd, s_se, s_pop, s_push;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1; ready = 1'b1;

        // Full 4x2 frame
        s_sop = sop_seen; s_eop = eop_seen; s_fd = fd_seen;
        send(12'hA5C, 1'b0);
        check("t1_first_data", 64'(data), 64'({8'hAA, 2'b00, 8'h55, 2'b00, 8'hCC, 2'b00}));
        check("t1_first_sop", 64'(startofpacket), 64'd1);
        for (int i = 1; i < 8; i++) send(12'(i * 291), 1'b0);
        drain();
        check("t1_sop_count", 64'(sop_seen - s_sop), 64'd1);
        check("t1_eop_count", 64'(eop_seen - s_eop), 64'd1);
        check("t1_frame_done", 64'(fd_seen - s_fd), 64'd1);
        check("t1_eop_on_8th", 64'(eop_idx), 64'd8);

        // Backpressure
        ready = 1'b0;
        s_pop = pop_seen;
        send(12'h123, 1'b0);
        send(12'h456, 1'b0);
        s_push = push_cnt;
        fork
            send(12'h789, 1'b0);
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("bp_in_ready", 64'(in_ready), 64'd0);
                    check("bp_hold", 64'(data), 64'({8'h11, 2'b00, 8'h22, 2'b00, 8'h33, 2'b00}));
                end
                check("bp_accepted", 64'(push_cnt - s_push), 64'd0);
                @(posedge clk); #1 ready = 1'b1;
            end
        join
        drain();
        check("bp_pops", 64'(pop_seen - s_pop), 64'd3);
        for (int i = 0; i < 5; i++) send(12'(i * 77 + 5), 1'b0);
        drain();

        // Resync on the 3rd pixel of a frame
        s_pop = pop_seen; s_se = se_seen; s_eop = eop_seen;
        send(12'h001, 1'b0);
        send(12'h002, 1'b0);
        send(12'h003, 1'b1);
        for (int i = 0; i < 7; i++) send(12'(i + 16), 1'b0);
        drain();
        check("rs_sync_error", 64'(se_seen - s_se), 64'd1);
        check("rs_eop_count", 64'(eop_seen - s_eop), 64'd1);
        check("rs_eop_pos", 64'(eop_idx - s_pop), 64'd10);

        // Reset mid-frame at pixel 5
        for (int i = 0; i < 5; i++) send(12'(i + 40), 1'b0);
        ready = 1'b0;
        send(12'hEEE, 1'b0);
        reset_n = 1'b0;
        #1;
        check("mr_valid", 64'(valid), 64'd0);
        check("mr_data", 64'(data), 64'd0);
        check("mr_in_ready", 64'(in_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1; ready = 1'b1;
        s_sop = sop_seen;
        send(12'h0F0, 1'b0);
        check("mr_next_sop", 64'(startofpacket), 64'd1);
        drain();
        check("mr_sop_count", 64'(sop_seen - s_sop), 64'd1);

        // 5-bit input expansion
        in_data5 = {5'b10110, 5'h00, 5'h1F}; in_valid5 = 1'b1;
        @(posedge clk); #1 in_valid5 = 1'b0;
        check("x5_valid", 64'(valid5), 64'd1);
        check("x5_word_a", 64'(data5), 64'({8'b10110101, 2'b00, 8'h00, 2'b00, 8'hFF, 2'b00}));
        check("x5_sop_eop", {62'd0, sop5, eop5}, 64'h2);
        ready5 = 1'b1;
        @(posedge clk); #1 ready5 = 1'b0;
        in_data5 = {5'h1F, 5'b10110, 5'h01}; in_valid5 = 1'b1;
        @(posedge clk); #1 in_valid5 = 1'b0;
        check("x5_word_b", 64'(data5), 64'({8'hFF, 2'b00, 8'b10110101, 2'b00, 8'h08, 2'b00}));
        check("x5_status", {61'd0, in_ready5, fd5, se5}, 64'h4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
